// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers, plus MTHI/MTLO/MFHI/MFLO.
// Optional macro MULDIV_EARLY_TERM_EN: multiplies exit once the remaining multiplier bits are zero.

module ex_muldiv_unit #(
   parameter int unsigned DATA_SIZE = 32,
   parameter int unsigned OP_SIZE   = 3,
   parameter int unsigned CNT_SIZE  = 6
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   input  logic [OP_SIZE-1:0]   i_op,
   input  logic [DATA_SIZE-1:0] i_data_a,
   input  logic [DATA_SIZE-1:0] i_data_b,
   input  logic                 i_flush,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [DATA_SIZE-1:0] o_result,
   output logic [DATA_SIZE-1:0] o_hi,
   output logic [DATA_SIZE-1:0] o_lo,
   output logic                 o_div_zero
);

   localparam int unsigned W     = DATA_SIZE;
   localparam int unsigned ACC_W = 2 * DATA_SIZE;

   localparam logic [OP_SIZE-1:0] OP_MULT  = OP_SIZE'(0);
   localparam logic [OP_SIZE-1:0] OP_MULTU = OP_SIZE'(1);
   localparam logic [OP_SIZE-1:0] OP_DIV   = OP_SIZE'(2);
   localparam logic [OP_SIZE-1:0] OP_DIVU  = OP_SIZE'(3);
   localparam logic [OP_SIZE-1:0] OP_MTHI  = OP_SIZE'(4);
   localparam logic [OP_SIZE-1:0] OP_MTLO  = OP_SIZE'(5);
   localparam logic [OP_SIZE-1:0] OP_MFHI  = OP_SIZE'(6);
   localparam logic [OP_SIZE-1:0] OP_MFLO  = OP_SIZE'(7);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_e;

   state_e              state_q;
   logic [CNT_SIZE-1:0] cnt_q;
   logic [ACC_W-1:0]    acc_q;
   logic [W-1:0]        opb_q;
   logic                neg_q;
   logic                rneg_q;
   logic                is_div_q;
   logic [W-1:0]        hi_q;
   logic [W-1:0]        lo_q;
   logic                busy_q;
   logic                done_q;
   logic                dz_q;

   logic                op_signed;
   logic [W-1:0]        a_mag;
   logic [W-1:0]        b_mag;
   logic [W-1:0]        mul_addend;
   logic [W:0]          mul_sum;
   logic [ACC_W-1:0]    mul_next;
   logic [W:0]          div_sh;
   logic                div_ok;
   logic [W-1:0]        div_rem;
   logic [ACC_W-1:0]    div_next;
   logic [CNT_SIZE-1:0] cnt_dec;
   logic                mul_last;
   logic [ACC_W-1:0]    prod;
   logic [ACC_W-1:0]    mul_res;
   logic [W-1:0]        q_res;
   logic [W-1:0]        r_res;

   function automatic logic [DATA_SIZE-1:0] abs_f(input logic [DATA_SIZE-1:0] x);
      return x[DATA_SIZE-1] ? -x : x;
   endfunction

   // Operand conditioning and one iteration of the shift-add / restoring-divide datapath.
   // acc_q holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
   always_comb begin
      op_signed  = (i_op == OP_MULT) || (i_op == OP_DIV);
      a_mag      = op_signed ? abs_f(i_data_a) : i_data_a;
      b_mag      = op_signed ? abs_f(i_data_b) : i_data_b;

      mul_addend = acc_q[0] ? opb_q : '0;
      mul_sum    = {1'b0, acc_q[ACC_W-1:W]} + {1'b0, mul_addend};
      mul_next   = {mul_sum, acc_q[W-1:1]};

      div_sh     = {acc_q[ACC_W-1:W], acc_q[W-1]};
      div_ok     = (div_sh >= {1'b0, opb_q});
      div_rem    = div_ok ? W'(div_sh - {1'b0, opb_q}) : div_sh[W-1:0];
      div_next   = {div_rem, acc_q[W-2:0], div_ok};

      cnt_dec    = cnt_q - CNT_SIZE'(1);
`ifdef MULDIV_EARLY_TERM_EN
      // Low cnt_dec bits of the next accumulator are the multiplier bits not yet consumed.
      mul_last   = (cnt_q == CNT_SIZE'(1)) ||
                   ((mul_next[W-1:0] << (CNT_SIZE'(W) - cnt_dec)) == '0);
      prod       = acc_q >> cnt_q;
`else
      mul_last   = (cnt_q == CNT_SIZE'(1));
      prod       = acc_q;
`endif
      mul_res    = neg_q ? -prod : prod;
      q_res      = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
      r_res      = rneg_q ? -acc_q[ACC_W-1:W] : acc_q[ACC_W-1:W];
   end

   // Control FSM, iteration registers and HI/LO.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opb_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         is_div_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_valid && !i_flush) begin
                  case (i_op)
                     OP_MULT, OP_MULTU: begin
                        opb_q    <= a_mag;
                        acc_q    <= {{W{1'b0}}, b_mag};
                        neg_q    <= op_signed & (i_data_a[W-1] ^ i_data_b[W-1]);
                        rneg_q   <= 1'b0;
                        is_div_q <= 1'b0;
                        cnt_q    <= CNT_SIZE'(W);
                        busy_q   <= 1'b1;
                        state_q  <= ST_MUL;
                     end
                     OP_DIV, OP_DIVU: begin
                        opb_q    <= b_mag;
                        acc_q    <= {{W{1'b0}}, a_mag};
                        neg_q    <= op_signed & (i_data_a[W-1] ^ i_data_b[W-1]);
                        rneg_q   <= op_signed & i_data_a[W-1];
                        is_div_q <= 1'b1;
                        cnt_q    <= CNT_SIZE'(W);
                        busy_q   <= 1'b1;
                        state_q  <= ST_DIV;
                        if (i_data_b == '0) begin
                           dz_q <= 1'b1;
                        end
                     end
                     OP_MTHI: hi_q <= i_data_a;
                     OP_MTLO: lo_q <= i_data_a;
                     default: ;
                  endcase
               end
            end
            ST_MUL: begin
               if (i_flush) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  acc_q <= mul_next;
                  cnt_q <= cnt_dec;
                  if (mul_last) begin
                     state_q <= ST_FIX;
                  end
               end
            end
            ST_DIV: begin
               if (i_flush) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  acc_q <= div_next;
                  cnt_q <= cnt_dec;
                  if (cnt_q == CNT_SIZE'(1)) begin
                     state_q <= ST_FIX;
                  end
               end
            end
            ST_FIX: begin
               // A squash arriving together with the commit wins: HI/LO stay untouched.
               if (!i_flush) begin
                  if (is_div_q) begin
                     hi_q <= r_res;
                     lo_q <= q_res;
                  end else begin
                     hi_q <= mul_res[ACC_W-1:W];
                     lo_q <= mul_res[W-1:0];
                  end
                  done_q <= 1'b1;
               end
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Move-from read port reflects the latest committed HI/LO.
   always_comb begin
      o_result = '0;
      if (i_op == OP_MFHI) begin
         o_result = hi_q;
      end else if (i_op == OP_MFLO) begin
         o_result = lo_q;
      end
   end

   assign o_busy     = busy_q;
   assign o_done     = done_q;
   assign o_hi       = hi_q;
   assign o_lo       = lo_q;
   assign o_div_zero = dz_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: expected HI/LO queued at issue, popped when o_done fires.

module tb_ex_muldiv_unit;

   logic        clk;
   logic        rst_n;
   logic        valid;
   logic [2:0]  op;
   logic [31:0] data_a;
   logic [31:0] data_b;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_zero;

   int total = 0;
   int bad   = 0;
   logic [63:0] exp_q[$];

   ex_muldiv_unit #(.DATA_SIZE(32), .OP_SIZE(3), .CNT_SIZE(6)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_valid    (valid),
      .i_op       (op),
      .i_data_a   (data_a),
      .i_data_b   (data_b),
      .i_flush    (flush),
      .o_busy     (busy),
      .o_done     (done),
      .o_result   (result),
      .o_hi       (hi),
      .o_lo       (lo),
      .o_div_zero (div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference {HI, LO} built from native 64-bit arithmetic.
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (o)
         3'd0: begin p = sa * sb; return p; end
         3'd1: begin p = {32'b0, a} * {32'b0, b}; return p; end
         3'd2: begin
            if (b == 32'd0) return {a, (a[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
            q = sa / sb;
            r = sa % sb;
            p = {r[31:0], q[31:0]};
            return p;
         end
         3'd3: begin
            if (b == 32'd0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'd0;
      endcase
   endfunction

   // Issue one op, then count busy cycles until o_done (bounded) and check it is a single pulse.
   task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int busy_n, output int done_n, output bit to);
      @(negedge clk);
      valid = 1'b1; op = o; data_a = a; data_b = b;
      @(negedge clk);
      valid = 1'b0;
      busy_n = 0; done_n = 0; to = 1'b1;
      for (int i = 0; i < 100; i++) begin
         if (busy) busy_n++;
         if (done) begin done_n++; to = 1'b0; break; end
         @(negedge clk);
      end
      if (!to) begin
         @(negedge clk);
         if (done) done_n++;
      end
   endtask

   task automatic check_result(input string name, input bit to, input int done_n);
      logic [63:0] e;
      total++;
      if (to || done_n != 1) begin
         bad++;
         $display("FAIL %s_done: timeout=%0d pulses=%0d want pulses=1", name, to, done_n);
      end
      e = exp_q.pop_front();
      total++;
      if ({hi, lo} !== e) begin
         bad++;
         $display("FAIL %s_hilo: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, e[63:32], e[31:0]);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; valid = 1'b0; op = 3'd0; data_a = '0; data_b = '0; flush = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
         bad++;
         $display("FAIL reset: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0", busy, done, div_zero, hi, lo);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_mult();
      int bn, dn; bit to;
      exp_q.push_back(model(3'd0, 32'hFFFF_FFFD, 32'd7));
      run_op(3'd0, 32'hFFFF_FFFD, 32'd7, bn, dn, to);
      total++;
      if (bn != 33) begin bad++; $display("FAIL mult_busy: got %0d want 33", bn); end
      check_result("mult", to, dn);
      total++;
      if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
         bad++; $display("FAIL mult_const: got %h want ffffffffffffffeb", {hi, lo});
      end
   endtask

   task automatic test_div();
      int bn, dn; bit to;
      exp_q.push_back(model(3'd3, 32'd100, 32'd7));
      run_op(3'd3, 32'd100, 32'd7, bn, dn, to);
      total++;
      if (bn != 33) begin bad++; $display("FAIL divu_busy: got %0d want 33", bn); end
      check_result("divu", to, dn);
      exp_q.push_back(model(3'd2, 32'hFFFF_FF9C, 32'd7));
      run_op(3'd2, 32'hFFFF_FF9C, 32'd7, bn, dn, to);
      check_result("div_neg", to, dn);
      total++;
      if ({hi, lo} !== 64'hFFFF_FFFE_FFFF_FFF2) begin
         bad++; $display("FAIL div_neg_const: got %h want fffffffefffffff2", {hi, lo});
      end
   endtask

   task automatic test_div_edge();
      int bn, dn; bit to;
      total++;
      if (div_zero !== 1'b0) begin bad++; $display("FAIL dz_clear: got %b want 0", div_zero); end
      exp_q.push_back({32'd5, 32'hFFFF_FFFF});
      run_op(3'd2, 32'd5, 32'd0, bn, dn, to);
      check_result("div_zero", to, dn);
      total++;
      if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_set: got %b want 1", div_zero); end
      exp_q.push_back({32'd0, 32'h8000_0000});
      run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, bn, dn, to);
      check_result("div_ovf", to, dn);
      total++;
      if (div_zero !== 1'b1) begin bad++; $display("FAIL dz_sticky: got %b want 1", div_zero); end
   endtask

   task automatic test_move();
      int busy_seen = 0;
      @(negedge clk);
      valid = 1'b1; op = 3'd4; data_a = 32'h1234_5678;
      @(negedge clk);
      op = 3'd6; data_a = '0;
      #1;
      if (busy) busy_seen++;
      total++;
      if (result !== 32'h1234_5678) begin bad++; $display("FAIL mfhi: got %h want 12345678", result); end
      @(negedge clk);
      op = 3'd5; data_a = 32'hCAFE_F00D;
      @(negedge clk);
      op = 3'd7;
      #1;
      if (busy) busy_seen++;
      total++;
      if (result !== 32'hCAFE_F00D) begin bad++; $display("FAIL mflo: got %h want cafef00d", result); end
      // Flushed MTHI in IDLE must not write.
      @(negedge clk);
      op = 3'd4; data_a = 32'hDEAD_0000; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; valid = 1'b0; op = 3'd6;
      #1;
      if (busy) busy_seen++;
      total++;
      if (result !== 32'h1234_5678) begin bad++; $display("FAIL flush_idle: got %h want 12345678", result); end
      op = 3'd0;
      #1;
      total++;
      if (result !== 32'd0) begin bad++; $display("FAIL result_other: got %h want 0", result); end
      total++;
      if (busy_seen != 0) begin bad++; $display("FAIL move_busy: got %0d want 0", busy_seen); end
   endtask

   task automatic test_busy_ignore();
      int dn = 0; bit to = 1'b1;
      exp_q.push_back({32'h1234_5678, 32'd42});
      exp_q[0][63:32] = 32'd0;
      @(negedge clk);
      valid = 1'b1; op = 3'd1; data_a = 32'd6; data_b = 32'd7;
      @(negedge clk);
      op = 3'd5; data_a = 32'h0000_0055;
      repeat (5) @(negedge clk);
      valid = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (done) begin dn = 1; to = 1'b0; break; end
         @(negedge clk);
      end
      check_result("busy_ignore", to, dn);
   endtask

   task automatic test_flush();
      int dn = 0;
      @(negedge clk); valid = 1'b1; op = 3'd4; data_a = 32'hAAAA_5555;
      @(negedge clk); op = 3'd5; data_a = 32'h0F0F_0F0F;
      @(negedge clk); op = 3'd1; data_a = 32'hFFFF_FFFF; data_b = 32'd2;
      @(negedge clk); valid = 1'b0;
      repeat (9) @(negedge clk);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL flush_pre_busy: got %b want 1", busy); end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", busy); end
      for (int i = 0; i < 40; i++) begin
         if (done) dn++;
         @(negedge clk);
      end
      total++;
      if (dn != 0) begin bad++; $display("FAIL flush_done: got %0d pulses want 0", dn); end
      total++;
      if ({hi, lo} !== 64'hAAAA_5555_0F0F_0F0F) begin
         bad++; $display("FAIL flush_hilo: got %h want aaaa55550f0f0f0f", {hi, lo});
      end
   endtask

   task automatic test_rst_mid();
      int bn, dn; bit to;
      @(negedge clk); valid = 1'b1; op = 3'd2; data_a = 32'd1000; data_b = 32'd3;
      @(negedge clk); valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({busy, done, div_zero, hi, lo} !== 67'd0) begin
         bad++;
         $display("FAIL rst_mid: got busy=%b done=%b dz=%b hi=%h lo=%h want all 0", busy, done, div_zero, hi, lo);
      end
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.push_back(model(3'd1, 32'd3, 32'd5));
      run_op(3'd1, 32'd3, 32'd5, bn, dn, to);
      check_result("post_rst", to, dn);
   endtask

   task automatic test_early_term();
      int bn, dn; bit to;
      exp_q.push_back(64'd27);
      run_op(3'd1, 32'd9, 32'd3, bn, dn, to);
      total++;
`ifdef MULDIV_EARLY_TERM_EN
      if (bn < 2 || bn > 3) begin bad++; $display("FAIL et_busy: got %0d want 2..3", bn); end
`else
      if (bn != 33) begin bad++; $display("FAIL et_busy: got %0d want 33", bn); end
`endif
      check_result("et", to, dn);
   endtask

   task automatic test_back_to_back();
      int bn, dn; bit to;
      logic [2:0]  o;
      logic [31:0] a, b;
      for (int n = 0; n < 12; n++) begin
         o = 3'($urandom_range(0, 3));
         a = $urandom();
         b = (n % 3 == 0) ? 32'($urandom_range(0, 255)) : $urandom();
         if (o >= 3'd2 && b == 32'd0) b = 32'd1;
         exp_q.push_back(model(o, a, b));
         run_op(o, a, b, bn, dn, to);
         check_result("b2b", to, dn);
         total++;
`ifdef MULDIV_EARLY_TERM_EN
         if ((o >= 3'd2 && bn != 33) || bn < 2 || bn > 33) begin
`else
         if (bn != 33) begin
`endif
            bad++; $display("FAIL b2b_busy: op=%0d got %0d cycles", o, bn);
         end
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_div_edge();
      test_move();
      test_busy_ignore();
      test_flush();
      test_rst_mid();
      test_early_term();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
